fetch_stage: RTL and testbench

//  Instruction fetch stage, directly upstream of the decode stage. Owns the PC.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 62 ++++++
 rtl/fetch_stage.sv | 102 ++++++++++
 tb/tb_fetch_stage.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   INSTR_W / PC_W : widths the fetch_entry_t record is built from
//   OPC_HALT       : opcode (top three instruction bits) that stops fetching
//   fetch_entry_t  : one buffered instruction together with its PC
package fetch_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned PC_W    = 8;

  localparam logic [2:0] OPC_HALT = 3'b111;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch_entry_t records between imem return and decode.
//   clk, reset : clock, synchronous active-high reset
//   push       : write push_data at the tail this cycle
//   push_data  : entry to enqueue
//   pop        : drop the head this cycle
//   flush      : same-cycle clear of all entries (wins over push/pop)
//   head       : current head entry (undefined contents when count == 0)
//   count      : occupancy, 0..DEPTH
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Storage is not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (!reset && !flush && push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

  // The upstream credit rule must never let the FIFO overflow or underflow.
  a_no_overflow : assert property (@(posedge clk) disable iff (reset || flush)
    !(push && !pop && (count_q == CW'(DEPTH))));
  a_no_underflow : assert property (@(posedge clk) disable iff (reset || flush)
    !(pop && (count_q == '0)));

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, reads a 1-cycle-latency instruction
// memory, buffers {pc, instruction} in fetch_fifo and hands them to decode.
//   clk, reset   : clock, synchronous active-high reset
//   imem_rd      : read request this cycle; imem_addr always equals the PC
//   imem_rdata   : read data, valid the cycle after imem_rd
//   redirect     : flush everything and restart fetch at redirect_pc
//   instr_valid  : FIFO head presented to decode; instr_ready accepts it
//   instruction  : head instruction (0 when not valid)
//   instr_pc     : head PC (0 when not valid)
//   halted       : a HALT has been enqueued; fetch stopped until redirect/reset
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned     N_INSTR  = 16,
  parameter int unsigned     N_PC     = 8,
  parameter int unsigned     DEPTH    = 2,
  parameter logic [N_PC-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_rd,
  output logic [N_PC-1:0]    imem_addr,
  input  logic [N_INSTR-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [N_PC-1:0]    redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [N_INSTR-1:0] instruction,
  output logic [N_PC-1:0]    instr_pc,
  output logic               halted
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  if (DEPTH < 2) begin : g_depth_chk
    $error("fetch_stage: DEPTH must be at least 2");
  end
  if (N_INSTR != INSTR_W || N_PC != PC_W) begin : g_width_chk
    $error("fetch_stage: N_INSTR/N_PC must match fetch_pkg entry widths");
  end

  logic [N_PC-1:0] pc_q;
  logic            inflight_q;
  logic [N_PC-1:0] inflight_pc_q;
  logic            halted_q;

  logic            push, pop;
  logic            push_is_halt;
  logic [CW:0]     credit_used;
  logic [CW-1:0]   fifo_count;
  fetch_entry_t    push_entry, head;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect),
    .head      (head),
    .count     (fifo_count)
  );

  always_comb begin
    instr_valid  = (fifo_count != '0) & ~redirect & ~reset;
    pop          = instr_valid & instr_ready;
    push         = inflight_q & ~redirect & ~halted_q;
    push_entry   = '{pc: inflight_pc_q, instr: imem_rdata};
    push_is_halt = push & (imem_rdata[N_INSTR-1 -: 3] == OPC_HALT);
    // Entries that will still occupy the FIFO after this cycle, counting the
    // outstanding read as already booked; never exceeds DEPTH.
    credit_used  = {1'b0, fifo_count} - (CW + 1)'(pop) + (CW + 1)'(inflight_q);
    imem_rd      = ~reset & ~halted_q & ~redirect & (credit_used < (CW + 1)'(DEPTH));
    imem_addr    = pc_q;
    instruction  = instr_valid ? head.instr : '0;
    instr_pc     = instr_valid ? head.pc    : '0;
    halted       = halted_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      halted_q      <= 1'b0;
    end else begin
      // imem_rd is already low during redirect, so this also clears inflight.
      inflight_q <= imem_rd;
      if (imem_rd) inflight_pc_q <= pc_q;
      if (redirect) begin
        pc_q     <= redirect_pc;
        halted_q <= 1'b0;
      end else begin
        if (imem_rd)      pc_q     <= pc_q + 1'b1;
        if (push_is_halt) halted_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_rd;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [15:0] instruction;
  logic [7:0]  instr_pc;
  logic        halted;

  int vectors = 0;
  int miscompares = 0;

  logic [23:0] exp_q [$];
  logic [15:0] imem [256];

  always #5 clk = ~clk;

  fetch_stage #(
    .N_INSTR  (16),
    .N_PC     (8),
    .DEPTH    (2),
    .RESET_PC (8'h00)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_rd     (imem_rd),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instruction (instruction),
    .instr_pc    (instr_pc),
    .halted      (halted)
  );

  // Synchronous instruction memory, 1-cycle read latency.
  always @(posedge clk) if (imem_rd) imem_rdata <= imem[imem_addr];

  // Scoreboard monitor: every completed handshake is checked against the queue.
  always @(negedge clk) begin
    if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
      logic [23:0] e;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL deliver_unexpected: got pc %h instr %h, required no delivery",
                 instr_pc, instruction);
      end else begin
        e = exp_q.pop_front();
        if ({instr_pc, instruction} !== e) begin
          miscompares++;
          $display("FAIL deliver: got pc %h instr %h, required pc %h instr %h",
                   instr_pc, instruction, e[23:16], e[15:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_entry(input logic [7:0] pc, input logic [15:0] ins);
    exp_q.push_back({pc, ins});
  endtask

  // Leaves the bench 1 time unit into cycle 0 with reset released.
  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    check("reset_imem_rd", imem_rd, 0);
    check("reset_valid", instr_valid, 0);
    cyc();
    reset = 1'b0;
  endtask

  // Returns at posedge+1 right after the queue empties, so the caller can drop
  // instr_ready before any further handshake.
  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      cyc();
      if (exp_q.size() == 0) break;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 16'h0100 + 16'(i);

    // 1: streaming from reset, one per cycle; 6: reset pulse in steady state.
    instr_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 8; i++) expect_entry(8'(i), 16'h0100 + 16'(i));
    @(negedge clk);
    check("s1_rd_c0", imem_rd, 1);
    check("s1_addr_c0", imem_addr, 8'h00);
    check("s1_valid_c0", instr_valid, 0);
    check("s1_instr_idle", instruction, 0);
    check("s1_pc_idle", instr_pc, 0);
    check("s1_halted_c0", halted, 0);
    cyc(); @(negedge clk);
    check("s1_valid_c1", instr_valid, 0);
    for (int c = 2; c < 10; c++) begin
      cyc(); @(negedge clk);
      check("s1_no_gap", instr_valid, 1);
    end
    cyc();
    reset = 1'b1;
    @(negedge clk);
    check("s6_valid_in_reset", instr_valid, 0);
    check("s6_rd_in_reset", imem_rd, 0);
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) expect_entry(8'(i), 16'h0100 + 16'(i));
    @(negedge clk);
    check("s6_count_after", dut.fifo_count, 0);
    check("s6_valid_after", instr_valid, 0);
    check("s6_addr_after", imem_addr, 8'h00);
    cyc(); @(negedge clk);
    check("s6_valid_c1", instr_valid, 0);
    cyc(); @(negedge clk);
    check("s6_valid_c2", instr_valid, 1);
    check("s6_pc_c2", instr_pc, 8'h00);
    wait_drain("s6_drain", 10);
    instr_ready = 1'b0;

    // 2: backpressure for 5 cycles after the first valid.
    do_reset();
    for (int i = 0; i < 6; i++) expect_entry(8'(i), 16'h0100 + 16'(i));
    cyc();
    for (int c = 2; c < 7; c++) begin
      cyc(); @(negedge clk);
      check("s2_hold_valid", instr_valid, 1);
      check("s2_hold_instr", instruction, 16'h0100);
      check("s2_hold_pc", instr_pc, 8'h00);
      check("s2_credit", (32'(dut.fifo_count) + 32'(dut.inflight_q)) <= 2, 1);
      if (c >= 3) check("s2_rd_stalled", imem_rd, 0);
    end
    cyc();
    instr_ready = 1'b1;
    wait_drain("s2_drain", 20);
    instr_ready = 1'b0;

    // 3: redirect while work is buffered and in flight.
    do_reset();
    cyc();
    cyc();
    redirect = 1'b1;
    redirect_pc = 8'h40;
    @(negedge clk);
    check("s3_valid_redirect", instr_valid, 0);
    check("s3_rd_redirect", imem_rd, 0);
    cyc();
    redirect = 1'b0;
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) expect_entry(8'h40 + 8'(i), 16'h0140 + 16'(i));
    @(negedge clk);
    check("s3_addr_after", imem_addr, 8'h40);
    check("s3_rd_after", imem_rd, 1);
    check("s3_valid_after", instr_valid, 0);
    cyc(); @(negedge clk);
    check("s3_no_stale", instr_valid, 0);
    wait_drain("s3_drain", 10);
    instr_ready = 1'b0;

    // 4: HALT at pc 3, then redirect resumes.
    imem[3] = 16'hE000;
    instr_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 3; i++) expect_entry(8'(i), 16'h0100 + 16'(i));
    expect_entry(8'h03, 16'hE000);
    for (int c = 1; c < 5; c++) begin
      cyc(); @(negedge clk);
      check("s4_not_halted", halted, 0);
    end
    cyc(); @(negedge clk);
    check("s4_halted", halted, 1);
    check("s4_rd_stop", imem_rd, 0);
    for (int c = 6; c < 10; c++) begin
      cyc(); @(negedge clk);
      check("s4_rd_stays_0", imem_rd, 0);
      check("s4_no_pc4", instr_valid, 0);
    end
    cyc();
    redirect = 1'b1;
    redirect_pc = 8'h10;
    @(negedge clk);
    check("s4_halted_in_redirect", halted, 1);
    cyc();
    redirect = 1'b0;
    expect_entry(8'h10, 16'h0110);
    expect_entry(8'h11, 16'h0111);
    @(negedge clk);
    check("s4_resume_halted", halted, 0);
    check("s4_resume_rd", imem_rd, 1);
    check("s4_resume_addr", imem_addr, 8'h10);
    wait_drain("s4_drain", 10);
    instr_ready = 1'b0;
    imem[3] = 16'h0103;

    // 5: PC wrap from FE.
    instr_ready = 1'b1;
    do_reset();
    redirect = 1'b1;
    redirect_pc = 8'hFE;
    @(negedge clk);
    check("s5_rd_redirect", imem_rd, 0);
    cyc();
    redirect = 1'b0;
    expect_entry(8'hFE, 16'h01FE);
    expect_entry(8'hFF, 16'h01FF);
    expect_entry(8'h00, 16'h0100);
    expect_entry(8'h01, 16'h0101);
    @(negedge clk);
    check("s5_addr", imem_addr, 8'hFE);
    wait_drain("s5_drain", 12);
    instr_ready = 1'b0;

    repeat (3) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
